// File: rtl/adc_cnv_sequencer.sv
// -----------------------------------------------------------------------------
// adc_cnv_sequencer
//
// Conversion sequencer for the quad-SDI ADC front end. A free-running period
// timer produces one tick per sample period. Each tick accepted in IDLE drives
// the ADC CNV pin high for CNV_HIGH_CYCLES cycles. It then waits until
// CONV_WAIT_CYCLES cycles after the CNV rise and pulses start_acq to the SPI
// controller. The word returned with acq_done is presented on a one-entry
// AXI-Stream master. Software register writes are arbitrated onto the
// controller's start_reg_wrt path only while no conversion is in flight.
//
// Optional feature macro: ADC_SEQ_OVERRUN_CNT_EN
//   defined   -> overrun_count is a saturating 16-bit event counter
//   undefined -> overrun_count is tied to 0 (sticky overrun flag unaffected)
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   enable, period        run periodic conversions / sample period in cycles
//   adc_cnv               ADC convert-start pin
//   start_acq, acq_done   readout handshake with the SPI controller
//   cnv_data              conversion word, valid with acq_done
//   start_reg_wrt,
//   reg_cmd, reg_wrt_done register write handshake with the SPI controller
//   reg_req, reg_cmd_in,
//   reg_ack               software register write request/acknowledge
//   m_axis_*              sample stream (AXI-Stream master, one entry)
//   overrun               sticky: tick skipped or sample dropped
//   overrun_count         saturating count of overrun events
// -----------------------------------------------------------------------------
module adc_cnv_sequencer #(
    parameter int unsigned CNV_HIGH_CYCLES  = 4,
    parameter int unsigned CONV_WAIT_CYCLES = 30,
    parameter int unsigned MIN_PERIOD       = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] period,
    output logic        adc_cnv,
    output logic        start_acq,
    input  logic        acq_done,
    input  logic [31:0] cnv_data,
    output logic        start_reg_wrt,
    output logic [23:0] reg_cmd,
    input  logic        reg_wrt_done,
    input  logic        reg_req,
    input  logic [23:0] reg_cmd_in,
    output logic        reg_ack,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        overrun,
    output logic [15:0] overrun_count
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CNV       = 3'd1,
        CONV_WAIT = 3'd2,
        READ      = 3'd3,
        REG       = 3'd4
    } state_t;

    localparam logic [31:0] MIN_PERIOD_W = 32'(MIN_PERIOD);
    // Phase counter value on the last cycle of each timed state.
    localparam logic [15:0] CNV_LAST     = 16'(CNV_HIGH_CYCLES - 1);
    localparam logic [15:0] WAIT_LAST    = 16'(CONV_WAIT_CYCLES - 1);

    // Reload value for the period timer: max(period, MIN_PERIOD) - 1.
    function automatic logic [31:0] reload_value(input logic [31:0] req);
        logic [31:0] eff;
        if (req < MIN_PERIOD_W) begin
            eff = MIN_PERIOD_W;
        end else begin
            eff = req;
        end
        return eff - 32'd1;
    endfunction

    state_t      state_r;
    state_t      state_nx_s;
    logic [31:0] timer_r;
    logic        enable_d_r;
    logic [15:0] phase_r;
    logic        tick_s;
    logic        skip_s;
    logic        capture_s;
    logic        drop_s;

    logic        adc_cnv_r;
    logic        start_acq_r;
    logic        start_reg_wrt_r;
    logic [23:0] reg_cmd_r;
    logic        reg_ack_r;
    logic [31:0] tdata_r;
    logic        tvalid_r;
    logic        overrun_r;

    // The timer is held at 0 while disabled and on the enable rising edge, so
    // the first tick lands on the cycle after enable rises.
    assign tick_s    = enable & enable_d_r & (timer_r == 32'd0);
    assign skip_s    = tick_s & (state_r != IDLE);
    assign capture_s = (state_r == READ) & acq_done & (~tvalid_r | m_axis_tready);
    assign drop_s    = (state_r == READ) & acq_done & tvalid_r & ~m_axis_tready;

    // Period timer: runs independently of the FSM so ticks never drift.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_r    <= 32'd0;
            enable_d_r <= 1'b0;
        end else begin
            enable_d_r <= enable;
            if (!enable || !enable_d_r) begin
                timer_r <= 32'd0;
            end else if (timer_r == 32'd0) begin
                timer_r <= reload_value(period);
            end else begin
                timer_r <= timer_r - 32'd1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic. A tick wins over a pending register request, and
    // a request is not re-accepted in the cycle its acknowledge is visible.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (tick_s) begin
                    state_nx_s = CNV;
                end else if (reg_req && !reg_ack_r) begin
                    state_nx_s = REG;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            CNV: begin
                if (phase_r == CNV_LAST) begin
                    state_nx_s = CONV_WAIT;
                end else begin
                    state_nx_s = CNV;
                end
            end
            CONV_WAIT: begin
                if (phase_r == WAIT_LAST) begin
                    state_nx_s = READ;
                end else begin
                    state_nx_s = CONV_WAIT;
                end
            end
            READ: begin
                if (acq_done) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = READ;
                end
            end
            REG: begin
                if (reg_wrt_done) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = REG;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Phase counter: 0 on the cycle adc_cnv rises, counts through CNV/CONV_WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_r <= 16'd0;
        end else if ((state_r == CNV) || (state_r == CONV_WAIT)) begin
            phase_r <= phase_r + 16'd1;
        end else begin
            phase_r <= 16'd0;
        end
    end

    // Registered handshake outputs toward the ADC and the SPI controller.
    always_ff @(posedge clk) begin
        if (reset) begin
            adc_cnv_r       <= 1'b0;
            start_acq_r     <= 1'b0;
            start_reg_wrt_r <= 1'b0;
            reg_cmd_r       <= 24'd0;
            reg_ack_r       <= 1'b0;
        end else begin
            adc_cnv_r       <= (state_nx_s == CNV);
            start_acq_r     <= (state_r == CONV_WAIT) && (state_nx_s == READ);
            start_reg_wrt_r <= (state_r == IDLE) && (state_nx_s == REG);
            reg_ack_r       <= (state_r == REG) && reg_wrt_done;
            if ((state_r == IDLE) && (state_nx_s == REG)) begin
                reg_cmd_r <= reg_cmd_in;
            end else begin
                reg_cmd_r <= reg_cmd_r;
            end
        end
    end

    // One-entry AXI-Stream holding register; a full, stalled entry is kept.
    always_ff @(posedge clk) begin
        if (reset) begin
            tdata_r  <= 32'd0;
            tvalid_r <= 1'b0;
        end else if (capture_s) begin
            tdata_r  <= cnv_data;
            tvalid_r <= 1'b1;
        end else if (m_axis_tready) begin
            tvalid_r <= 1'b0;
        end else begin
            tvalid_r <= tvalid_r;
        end
    end

    // Sticky overrun flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r | skip_s | drop_s;
        end
    end

`ifdef ADC_SEQ_OVERRUN_CNT_EN
    logic [15:0] overrun_count_r;
    logic [16:0] count_sum_s;

    // A skip and a drop can coincide, so both are added in one cycle.
    assign count_sum_s = {1'b0, overrun_count_r} + {16'd0, skip_s} + {16'd0, drop_s};

    // Saturating overrun event counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_count_r <= 16'd0;
        end else if (count_sum_s[16]) begin
            overrun_count_r <= 16'hFFFF;
        end else begin
            overrun_count_r <= count_sum_s[15:0];
        end
    end

    assign overrun_count = overrun_count_r;
`else
    assign overrun_count = 16'd0;
`endif

    assign adc_cnv       = adc_cnv_r;
    assign start_acq     = start_acq_r;
    assign start_reg_wrt = start_reg_wrt_r;
    assign reg_cmd       = reg_cmd_r;
    assign reg_ack       = reg_ack_r;
    assign m_axis_tdata  = tdata_r;
    assign m_axis_tvalid = tvalid_r;
    assign overrun       = overrun_r;

endmodule

// File: tb/tb_adc_cnv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_adc_cnv_sequencer
//
// Directed self-checking bench for adc_cnv_sequencer. A combined monitor and
// SPI-controller model logs event cycles into queues and answers start_acq /
// start_reg_wrt after programmable delays. Scenario tasks drive inputs on the
// falling edge and compare logged events against hand-computed cycle offsets.
// -----------------------------------------------------------------------------
module tb_adc_cnv_sequencer;

`ifdef ADC_SEQ_OVERRUN_CNT_EN
    localparam logic [15:0] EXP_CNT_BP    = 16'd1;
    localparam logic [15:0] EXP_CNT_SLOW1 = 16'd1;
    localparam logic [15:0] EXP_CNT_SLOW2 = 16'd2;
`else
    localparam logic [15:0] EXP_CNT_BP    = 16'd0;
    localparam logic [15:0] EXP_CNT_SLOW1 = 16'd0;
    localparam logic [15:0] EXP_CNT_SLOW2 = 16'd0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] period;
    logic        adc_cnv;
    logic        start_acq;
    logic        acq_done;
    logic [31:0] cnv_data;
    logic        start_reg_wrt;
    logic [23:0] reg_cmd;
    logic        reg_wrt_done;
    logic        reg_req;
    logic [23:0] reg_cmd_in;
    logic        reg_ack;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        overrun;
    logic [15:0] overrun_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int acq_delay = 40;
    int reg_delay = 5;

    int          rise_q[$];
    int          high_q[$];
    int          acq_q[$];
    int          done_q[$];
    logic [31:0] sent_q[$];
    logic [31:0] beat_q[$];
    int          srw_q[$];
    int          rdone_q[$];

    adc_cnv_sequencer #(
        .CNV_HIGH_CYCLES (4),
        .CONV_WAIT_CYCLES(30),
        .MIN_PERIOD      (64)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .period       (period),
        .adc_cnv      (adc_cnv),
        .start_acq    (start_acq),
        .acq_done     (acq_done),
        .cnv_data     (cnv_data),
        .start_reg_wrt(start_reg_wrt),
        .reg_cmd      (reg_cmd),
        .reg_wrt_done (reg_wrt_done),
        .reg_req      (reg_req),
        .reg_cmd_in   (reg_cmd_in),
        .reg_ack      (reg_ack),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .overrun      (overrun),
        .overrun_count(overrun_count)
    );

    always #5 clk = ~clk;

    // Cycle index: constant between consecutive rising edges.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor plus SPI controller model, evaluated mid low-phase.
    initial begin : monitor_model
        int          acq_cnt;
        int          reg_cnt;
        int          high_len;
        logic        prev_cnv;
        logic [31:0] data_seq;
        acq_cnt      = -1;
        reg_cnt      = -1;
        high_len     = 0;
        prev_cnv     = 1'b0;
        data_seq     = 32'hA500_1234;
        acq_done     = 1'b0;
        reg_wrt_done = 1'b0;
        cnv_data     = 32'd0;
        forever begin
            @(negedge clk);
            #2;
            acq_done     = 1'b0;
            reg_wrt_done = 1'b0;
            if (reset) begin
                acq_cnt  = -1;
                reg_cnt  = -1;
                prev_cnv = 1'b0;
                high_len = 0;
            end else begin
                if (adc_cnv && !prev_cnv) rise_q.push_back(cyc);
                if (adc_cnv) begin
                    high_len++;
                end else if (prev_cnv) begin
                    high_q.push_back(high_len);
                    high_len = 0;
                end
                prev_cnv = adc_cnv;
                if (start_acq) acq_q.push_back(cyc);
                if (m_axis_tvalid && m_axis_tready) beat_q.push_back(m_axis_tdata);
                if (start_reg_wrt) srw_q.push_back(cyc);
                if (acq_cnt > 0) begin
                    acq_cnt--;
                    if (acq_cnt == 0) begin
                        acq_done = 1'b1;
                        cnv_data = data_seq;
                        sent_q.push_back(data_seq);
                        done_q.push_back(cyc);
                        data_seq = data_seq + 32'h0101_0101;
                        acq_cnt  = -1;
                    end
                end
                if (start_acq) acq_cnt = acq_delay;
                if (reg_cnt > 0) begin
                    reg_cnt--;
                    if (reg_cnt == 0) begin
                        reg_wrt_done = 1'b1;
                        rdone_q.push_back(cyc);
                        reg_cnt = -1;
                    end
                end
                if (start_reg_wrt) reg_cnt = reg_delay;
            end
        end
    end

    task automatic clear_logs();
        rise_q.delete(); high_q.delete(); acq_q.delete(); done_q.delete();
        sent_q.delete(); beat_q.delete(); srw_q.delete(); rdone_q.delete();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; period = 32'd100; m_axis_tready = 1'b1;
        reg_req = 1'b0; reg_cmd_in = 24'd0;
        repeat (3) @(negedge clk);
        total++; if (adc_cnv !== 1'b0) begin bad++; $display("FAIL rst_adc_cnv: got %0b want 0", adc_cnv); end
        total++; if (start_acq !== 1'b0) begin bad++; $display("FAIL rst_start_acq: got %0b want 0", start_acq); end
        total++; if (start_reg_wrt !== 1'b0) begin bad++; $display("FAIL rst_start_reg_wrt: got %0b want 0", start_reg_wrt); end
        total++; if (reg_ack !== 1'b0) begin bad++; $display("FAIL rst_reg_ack: got %0b want 0", reg_ack); end
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid: got %0b want 0", m_axis_tvalid); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rst_overrun: got %0b want 0", overrun); end
        total++; if (reg_cmd !== 24'd0) begin bad++; $display("FAIL rst_reg_cmd: got %0h want 0", reg_cmd); end
        total++; if (m_axis_tdata !== 32'd0) begin bad++; $display("FAIL rst_tdata: got %0h want 0", m_axis_tdata); end
        total++; if (overrun_count !== 16'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", overrun_count); end
        reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_free_run();
        int e;
        clear_logs();
        period = 32'd100; acq_delay = 40; m_axis_tready = 1'b1;
        @(negedge clk);
        e = cyc;
        enable = 1'b1;
        repeat (450) @(negedge clk);
        enable = 1'b0;
        repeat (150) @(negedge clk);
        total++; if (rise_q.size() !== 5) begin bad++; $display("FAIL free_rise_count: got %0d want 5", rise_q.size()); end
        if (rise_q.size() > 0) begin
            total++; if (rise_q[0] - e !== 2) begin bad++; $display("FAIL free_first_rise: got %0d want 2", rise_q[0] - e); end
        end
        for (int i = 1; i < rise_q.size(); i++) begin
            total++; if (rise_q[i] - rise_q[i-1] !== 100) begin bad++; $display("FAIL free_spacing[%0d]: got %0d want 100", i, rise_q[i] - rise_q[i-1]); end
        end
        for (int i = 0; i < high_q.size(); i++) begin
            total++; if (high_q[i] !== 4) begin bad++; $display("FAIL free_cnv_high[%0d]: got %0d want 4", i, high_q[i]); end
        end
        total++; if (acq_q.size() !== 5) begin bad++; $display("FAIL free_acq_count: got %0d want 5", acq_q.size()); end
        for (int i = 0; i < acq_q.size() && i < rise_q.size(); i++) begin
            total++; if (acq_q[i] - rise_q[i] !== 30) begin bad++; $display("FAIL free_acq_delay[%0d]: got %0d want 30", i, acq_q[i] - rise_q[i]); end
        end
        total++; if (beat_q.size() !== 5) begin bad++; $display("FAIL free_beat_count: got %0d want 5", beat_q.size()); end
        for (int i = 0; i < beat_q.size() && i < sent_q.size(); i++) begin
            total++; if (beat_q[i] !== sent_q[i]) begin bad++; $display("FAIL free_beat_data[%0d]: got %0h want %0h", i, beat_q[i], sent_q[i]); end
        end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL free_overrun: got %0b want 0", overrun); end
    endtask

    task automatic test_tvalid_latency();
        int e;
        int k;
        clear_logs();
        period = 32'd100; acq_delay = 20; m_axis_tready = 1'b0;
        @(negedge clk);
        e = cyc;
        enable = 1'b1;
        k = 0;
        while (!m_axis_tvalid && k < 200) begin
            @(negedge clk);
            k++;
        end
        enable = 1'b0;
        // tick e+1, rise e+2, start_acq e+32, acq_done e+52, tvalid e+53
        total++; if (cyc - e !== 53) begin bad++; $display("FAIL tvalid_latency: got %0d want 53", cyc - e); end
        if (done_q.size() > 0) begin
            total++; if (cyc - done_q[0] !== 1) begin bad++; $display("FAIL tvalid_after_done: got %0d want 1", cyc - done_q[0]); end
        end
        m_axis_tready = 1'b1;
        repeat (100) @(negedge clk);
    endtask

    task automatic test_clamp();
        clear_logs();
        period = 32'd10; acq_delay = 5; m_axis_tready = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        repeat (200) @(negedge clk);
        enable = 1'b0;
        repeat (100) @(negedge clk);
        total++; if (rise_q.size() !== 4) begin bad++; $display("FAIL clamp_rise_count: got %0d want 4", rise_q.size()); end
        for (int i = 1; i < rise_q.size(); i++) begin
            total++; if (rise_q[i] - rise_q[i-1] !== 64) begin bad++; $display("FAIL clamp_spacing[%0d]: got %0d want 64", i, rise_q[i] - rise_q[i-1]); end
        end
    endtask

    task automatic test_backpressure();
        clear_logs();
        period = 32'd100; acq_delay = 40; m_axis_tready = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        repeat (150) @(negedge clk);
        enable = 1'b0;
        repeat (50) @(negedge clk);
        total++; if (sent_q.size() !== 2) begin bad++; $display("FAIL bp_samples: got %0d want 2", sent_q.size()); end
        total++; if (m_axis_tvalid !== 1'b1) begin bad++; $display("FAIL bp_tvalid_held: got %0b want 1", m_axis_tvalid); end
        if (sent_q.size() > 0) begin
            total++; if (m_axis_tdata !== sent_q[0]) begin bad++; $display("FAIL bp_tdata_held: got %0h want %0h", m_axis_tdata, sent_q[0]); end
        end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL bp_overrun: got %0b want 1", overrun); end
        total++; if (overrun_count !== EXP_CNT_BP) begin bad++; $display("FAIL bp_count: got %0d want %0d", overrun_count, EXP_CNT_BP); end
        total++; if (beat_q.size() !== 0) begin bad++; $display("FAIL bp_no_beat: got %0d want 0", beat_q.size()); end
        m_axis_tready = 1'b1;
        @(negedge clk);
        total++; if (beat_q.size() !== 1) begin bad++; $display("FAIL bp_beat_count: got %0d want 1", beat_q.size()); end
        if (beat_q.size() > 0 && sent_q.size() > 0) begin
            total++; if (beat_q[0] !== sent_q[0]) begin bad++; $display("FAIL bp_beat_data: got %0h want %0h", beat_q[0], sent_q[0]); end
        end
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL bp_tvalid_clear: got %0b want 0", m_axis_tvalid); end
    endtask

    task automatic test_slow_readout();
        apply_reset();
        clear_logs();
        period = 32'd100; acq_delay = 150; m_axis_tready = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        repeat (100) @(negedge clk);
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL slow_no_overrun_yet: got %0b want 0", overrun); end
        repeat (2) @(negedge clk);
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL slow_overrun_set: got %0b want 1", overrun); end
        total++; if (overrun_count !== EXP_CNT_SLOW1) begin bad++; $display("FAIL slow_count1: got %0d want %0d", overrun_count, EXP_CNT_SLOW1); end
        repeat (348) @(negedge clk);
        enable = 1'b0;
        repeat (200) @(negedge clk);
        total++; if (rise_q.size() !== 3) begin bad++; $display("FAIL slow_rise_count: got %0d want 3", rise_q.size()); end
        for (int i = 1; i < rise_q.size(); i++) begin
            total++; if (rise_q[i] - rise_q[i-1] !== 200) begin bad++; $display("FAIL slow_spacing[%0d]: got %0d want 200", i, rise_q[i] - rise_q[i-1]); end
        end
        total++; if (overrun_count !== EXP_CNT_SLOW2) begin bad++; $display("FAIL slow_count2: got %0d want %0d", overrun_count, EXP_CNT_SLOW2); end
        total++; if (beat_q.size() !== 3) begin bad++; $display("FAIL slow_beats: got %0d want 3", beat_q.size()); end
    endtask

    task automatic test_reg_collision();
        int e;
        int k;
        clear_logs();
        period = 32'd1000; acq_delay = 40; reg_delay = 5; m_axis_tready = 1'b1;
        @(negedge clk);
        e = cyc;
        enable = 1'b1;
        @(negedge clk);
        reg_req = 1'b1; reg_cmd_in = 24'h123456;
        repeat (9) @(negedge clk);
        enable = 1'b0;
        k = 0;
        while (!reg_ack && k < 300) begin
            @(negedge clk);
            k++;
        end
        total++; if (reg_ack !== 1'b1) begin bad++; $display("FAIL col_ack_timeout: got %0b want 1", reg_ack); end
        total++; if (reg_cmd !== 24'h123456) begin bad++; $display("FAIL col_reg_cmd: got %0h want 123456", reg_cmd); end
        if (rdone_q.size() > 0) begin
            total++; if (cyc - rdone_q[0] !== 1) begin bad++; $display("FAIL col_ack_latency: got %0d want 1", cyc - rdone_q[0]); end
        end
        reg_req = 1'b0; reg_cmd_in = 24'd0;
        repeat (20) @(negedge clk);
        if (rise_q.size() > 0) begin
            total++; if (rise_q[0] - e !== 2) begin bad++; $display("FAIL col_cnv_first: got %0d want 2", rise_q[0] - e); end
        end
        total++; if (srw_q.size() !== 1) begin bad++; $display("FAIL col_wrt_count: got %0d want 1", srw_q.size()); end
        if (srw_q.size() > 0) begin
            total++; if (srw_q[0] - e !== 74) begin bad++; $display("FAIL col_wrt_cycle: got %0d want 74", srw_q[0] - e); end
        end
    endtask

    task automatic test_reset_conv_wait();
        int c;
        int k;
        clear_logs();
        period = 32'd100; acq_delay = 150; reg_delay = 5; m_axis_tready = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        repeat (210) @(negedge clk);
        total++; if (m_axis_tvalid !== 1'b1) begin bad++; $display("FAIL rcw_pre_tvalid: got %0b want 1", m_axis_tvalid); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL rcw_pre_overrun: got %0b want 1", overrun); end
        reset = 1'b1;
        @(negedge clk);
        total++; if (adc_cnv !== 1'b0) begin bad++; $display("FAIL rcw_adc_cnv: got %0b want 0", adc_cnv); end
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL rcw_tvalid: got %0b want 0", m_axis_tvalid); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rcw_overrun: got %0b want 0", overrun); end
        total++; if (overrun_count !== 16'd0) begin bad++; $display("FAIL rcw_count: got %0d want 0", overrun_count); end
        reset = 1'b0; enable = 1'b0;
        repeat (50) @(negedge clk);
        total++; if (acq_q.size() !== 1) begin bad++; $display("FAIL rcw_acq_dropped: got %0d want 1", acq_q.size()); end
        total++; if (rise_q.size() !== 2) begin bad++; $display("FAIL rcw_rises: got %0d want 2", rise_q.size()); end
        reg_req = 1'b1; reg_cmd_in = 24'hABCDEF;
        c = cyc;
        @(negedge clk);
        total++; if (start_reg_wrt !== 1'b1) begin bad++; $display("FAIL rcw_idle_wrt: got %0b want 1", start_reg_wrt); end
        total++; if (reg_cmd !== 24'hABCDEF) begin bad++; $display("FAIL rcw_reg_cmd: got %0h want abcdef", reg_cmd); end
        k = 0;
        while (!reg_ack && k < 50) begin
            @(negedge clk);
            k++;
        end
        total++; if (cyc - c !== 7) begin bad++; $display("FAIL rcw_ack_cycle: got %0d want 7", cyc - c); end
        reg_req = 1'b0;
        m_axis_tready = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_tvalid_latency();
        test_clamp();
        test_backpressure();
        test_slow_readout();
        test_reg_collision();
        test_reset_conv_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
